// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with thresholds, FWFT option and error pulses
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = (2 ** ADDR_W) - 2,
  parameter int AE_THRESH = 2,
  parameter bit FWFT      = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_rd,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_valid_out,
  output logic [ADDR_W:0]   o_fifo_cnt,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_almost_empty,
  output logic              o_almost_full,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  // Storage is deliberately left out of reset; only pointers and count define contents.
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_cnt;
  logic              r_overflow;
  logic              r_underflow;

  logic w_empty;
  logic w_full;
  logic w_almost_empty;
  logic w_almost_full;
  logic w_wr_acc;
  logic w_rd_acc;

  // Flags come only from the registered count, so rd/wr can never glitch them.
  assign w_empty        = (r_cnt == '0);
  assign w_full         = (r_cnt == CNT_FULL);
  assign w_almost_empty = (int'(r_cnt) <= AE_THRESH);
  assign w_almost_full  = (int'(r_cnt) >= AF_THRESH);

  // Acceptance uses start-of-cycle full/empty: a same-cycle read never frees
  // room for a write, and a same-cycle write never feeds a read.
  assign w_wr_acc = i_wr && !w_full;
  assign w_rd_acc = i_rd && !w_empty;

  // Store accepted write data at the write pointer.
  always_ff @(posedge i_clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= i_data_in;
    end
  end

  // Pointers wrap naturally modulo DEPTH.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Occupancy: gated acceptance keeps the count inside 0..DEPTH.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // One-cycle error pulses for rejected accesses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= i_wr && w_full;
      r_underflow <= i_rd && w_empty;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is always presented; rd just retires it.
      assign o_data_out  = r_mem[r_rd_ptr];
      assign o_valid_out = !w_empty;
    end else begin : g_std
      logic [DATA_W-1:0] r_data_out;
      logic              r_valid_out;

      // Registered read: data loads on an accepted read and otherwise holds.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_data_out  <= '0;
          r_valid_out <= 1'b0;
        end else begin
          r_valid_out <= w_rd_acc;
          if (w_rd_acc) begin
            r_data_out <= r_mem[r_rd_ptr];
          end
        end
      end

      assign o_data_out  = r_data_out;
      assign o_valid_out = r_valid_out;
    end
  endgenerate

  assign o_fifo_cnt     = r_cnt;
  assign o_empty        = w_empty;
  assign o_full         = w_full;
  assign o_almost_empty = w_almost_empty;
  assign o_almost_full  = w_almost_full;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule
